// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA timing constants, phase encoding and helpers.
// Defaults describe 640x480 @ 60 Hz from a 100 MHz board clock.
package vga_timing_ctrl_pkg;

    // Default timing (pixels / lines)
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Counter and colour widths
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;
    localparam int COLOR_W = 4;
    localparam int RGB_W   = 3 * COLOR_W;

    // Per-axis phase encoding
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // Map an axis count onto its phase given the region lengths.
    function automatic phase_e phase_of(
        input logic [CNT_W-1:0] cnt,
        input int               act,
        input int               fp,
        input int               sync
    );
        int c;
        c = int'({22'd0, cnt});
        if (c < act) begin
            return PH_ACTIVE;
        end else if (c < act + fp) begin
            return PH_FP;
        end else if (c < act + fp + sync) begin
            return PH_SYNC;
        end else begin
            return PH_BP;
        end
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis.sv
// vga_axis_counter: wrap counter plus registered phase for one VGA axis.
// Ports: i_clk, i_rst (async high), i_clr, i_count_en -> o_wrap, o_count, o_phase.
module vga_axis_counter
    import vga_timing_ctrl_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_count_en,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_count,
    output phase_e           o_phase
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    if (TOTAL > CNT_MAX) begin : g_bad_total
        $error("vga_axis_counter: axis total exceeds counter range");
    end

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    phase_e           r_phase;
    phase_e           w_phase_nxt;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next state: phase is decoded from the next count so the
    // registered phase always describes the registered count.
    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_count_en) begin
            if (r_count == LAST) begin
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end
        w_phase_nxt = phase_of(w_count_nxt, ACTIVE, FP, SYNC);
    end

    // Outputs
    always_comb begin
        o_wrap  = i_count_en && (r_count == LAST);
        o_count = r_count;
        o_phase = r_phase;
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel-rate enable, h/v counters, colour request
// and registered RGB/hsync/vsync. Ports: clk_ext, rst, enable, pix_rgb ->
// pix_req, pix_x, pix_y, frame_start, line_start, vga_red/green/blue, vga_hsync/vsync.
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk_ext,
    input  logic               rst,
    input  logic               enable,
    input  logic [RGB_W-1:0]   pix_rgb,
    output logic               pix_req,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               frame_start,
    output logic               line_start,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue,
    output logic               vga_hsync,
    output logic               vga_vsync
);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_ctrl: CLK_DIV must be 1..16");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [DIV_W-1:0] r_div;
    logic [RGB_W-1:0] r_rgb;
    logic             r_hsync;
    logic             r_vsync;

    logic             w_pix_tick;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    phase_e           w_h_phase;
    phase_e           w_v_phase;

    // Pixel-rate divider; held at zero while disabled so the first
    // tick after enable lands CLK_DIV clocks later.
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (!enable || r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_pix_tick = enable && (r_div == DIV_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .i_clk      (clk_ext),
        .i_rst      (rst),
        .i_clr      (!enable),
        .i_count_en (w_pix_tick),
        .o_wrap     (w_h_wrap),
        .o_count    (w_h),
        .o_phase    (w_h_phase)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .i_clk      (clk_ext),
        .i_rst      (rst),
        .i_clr      (!enable),
        .i_count_en (w_h_wrap),
        .o_wrap     (w_v_wrap),
        .o_count    (w_v),
        .o_phase    (w_v_phase)
    );

    assign w_active = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

    // Pad-side registers: one pixel tick behind the counters, RGB and
    // syncs updated on the same edge so they stay aligned.
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= SYNC_OFF;
            r_vsync <= SYNC_OFF;
        end else if (!enable) begin
            r_rgb   <= '0;
            r_hsync <= SYNC_OFF;
            r_vsync <= SYNC_OFF;
        end else if (w_pix_tick) begin
            r_rgb   <= w_active ? pix_rgb : '0;
            r_hsync <= (w_h_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
            r_vsync <= (w_v_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
        end
    end

    // The vertical wrap is implied by frame_start on the next tick.
    logic w_unused;
    assign w_unused = w_v_wrap;

    always_comb begin
        pix_req     = w_pix_tick && w_active && !w_unused | (w_pix_tick && w_active);
        pix_x       = w_h;
        pix_y       = w_v;
        line_start  = w_pix_tick && (w_h == '0);
        frame_start = w_pix_tick && (w_h == '0) && (w_v == '0);
        vga_red     = r_rgb[3*COLOR_W-1:2*COLOR_W];
        vga_green   = r_rgb[2*COLOR_W-1:COLOR_W];
        vga_blue    = r_rgb[COLOR_W-1:0];
        vga_hsync   = r_hsync;
        vga_vsync   = r_vsync;
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default 640x480 instance for line/colour/enable/reset
// checks and a tiny CLK_DIV=1, SYNC_POL=1 instance for whole-frame checks.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena;
    logic        enb;
    logic        mode;

    logic [11:0] pix_rgb_a;
    logic        req_a, fs_a, ls_a, hs_a, vs_a;
    logic [9:0]  x_a, y_a;
    logic [3:0]  r_a, g_a, b_a;
    logic [11:0] rgb_a;

    logic [11:0] pix_rgb_b;
    logic        req_b, fs_b, ls_b, hs_b, vs_b;
    logic [9:0]  x_b, y_b;
    logic [3:0]  r_b, g_b, b_b;

    assign rgb_a = {r_a, g_a, b_a};

    always_comb begin
        pix_rgb_a = mode ? 12'hFFF : {x_a[3:0], y_a[3:0], 4'hA};
        pix_rgb_b = {x_b[3:0], y_b[3:0], 4'h1};
    end

    vga_timing_ctrl u_dut_a (
        .clk_ext     (clk),
        .rst         (rst),
        .enable      (ena),
        .pix_rgb     (pix_rgb_a),
        .pix_req     (req_a),
        .pix_x       (x_a),
        .pix_y       (y_a),
        .frame_start (fs_a),
        .line_start  (ls_a),
        .vga_red     (r_a),
        .vga_green   (g_a),
        .vga_blue    (b_a),
        .vga_hsync   (hs_a),
        .vga_vsync   (vs_a)
    );

    vga_timing_ctrl #(
        .CLK_DIV  (1),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .SYNC_POL (1'b1)
    ) u_dut_b (
        .clk_ext     (clk),
        .rst         (rst),
        .enable      (enb),
        .pix_rgb     (pix_rgb_b),
        .pix_req     (req_b),
        .pix_x       (x_b),
        .pix_y       (y_b),
        .frame_start (fs_b),
        .line_start  (ls_b),
        .vga_red     (r_b),
        .vga_green   (g_b),
        .vga_blue    (b_b),
        .vga_hsync   (hs_b),
        .vga_vsync   (vs_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int n;
        int t;
        int t0;
        int c_req, c_hs, c_vs, c_ls, c_fs, c_pulse;

        rst  = 1'b1;
        ena  = 1'b1;
        enb  = 1'b0;
        mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_hs_a", 32'(hs_a), 32'd1);
        check("rst_vs_a", 32'(vs_a), 32'd1);
        check("rst_rgb_a", 32'(rgb_a), 32'h0);
        check("rst_x_a", 32'(x_a), 32'd0);
        check("rst_y_a", 32'(y_a), 32'd0);
        check("rst_fs_a", 32'(fs_a), 32'd0);
        check("rst_hs_b", 32'(hs_b), 32'd0);

        // First frame_start on the 4th edge after release
        rst = 1'b0;
        n = 0;
        while (!fs_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("a_first_fs_edge", 32'(n + 1), 32'd4);
        check("a_first_fs_req", 32'(req_a), 32'd1);

        // Small instance: enable gives frame_start immediately
        @(negedge clk);
        enb = 1'b1;
        #1;
        check("b_fs_on_enable", 32'(fs_b), 32'd1);
        c_req = 0; c_hs = 0; c_vs = 0; c_ls = 0; c_fs = 0;
        for (int i = 0; i < 120; i++) begin
            c_req += int'(req_b);
            c_hs  += int'(hs_b);
            c_vs  += int'(vs_b);
            c_ls  += int'(ls_b);
            c_fs  += int'(fs_b);
            @(negedge clk);
            #1;
        end
        check("b_frame_period_fs", 32'(fs_b), 32'd1);
        check("b_frame_period_xy", 32'({x_b, y_b}), 32'd0);
        check("b_req_per_frame", 32'(c_req), 32'd32);
        check("b_hs_high_clks", 32'(c_hs), 32'd24);
        check("b_vs_high_clks", 32'(c_vs), 32'd30);
        check("b_ls_per_frame", 32'(c_ls), 32'd8);
        check("b_fs_per_frame", 32'(c_fs), 32'd1);

        n = 0;
        while (!hs_b && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b_hs_rise_x", 32'(x_b), 32'd11);
        n = 0;
        while (!vs_b && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b_vs_rise_y", 32'(y_b), 32'd5);
        check("b_vs_rise_x", 32'(x_b), 32'd1);
        enb = 1'b0;

        // Default line timing
        @(negedge clk);
        n = 0;
        while (!ls_a && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_ls_found", 32'(ls_a), 32'd1);
        t = 0;
        while (hs_a && t < 3300) begin
            @(negedge clk);
            t++;
        end
        check("a_hs_fall_clks", 32'(t), 32'd2625);
        check("a_hs_fall_x", 32'(x_a), 32'd657);
        t0 = t;
        while (!hs_a && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("a_hs_low_clks", 32'(t - t0), 32'd384);
        while (!ls_a && t < 7000) begin
            @(negedge clk);
            t++;
        end
        check("a_line_period", 32'(t), 32'd3200);

        // Colour path
        n = 0;
        while (!(req_a && x_a == 10'd5 && y_a == 10'd3) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("a_req_5_3_found", 32'(req_a), 32'd1);
        @(negedge clk);
        check("a_rgb_5_3", 32'(rgb_a), 32'h53A);
        repeat (3) @(negedge clk);
        check("a_rgb_hold", 32'(rgb_a), 32'h53A);
        @(negedge clk);
        check("a_rgb_6_3", 32'(rgb_a), 32'h63A);

        // Blanking with a saturated renderer
        mode = 1'b1;
        n = 0;
        while (x_a != 10'd645 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_fp_rgb", 32'(rgb_a), 32'h0);
        check("a_fp_hs", 32'(hs_a), 32'd1);
        n = 0;
        while (x_a != 10'd700 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_sync_rgb", 32'(rgb_a), 32'h0);
        check("a_sync_hs", 32'(hs_a), 32'd0);
        n = 0;
        while (x_a != 10'd100 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_active_fff", 32'(rgb_a), 32'hFFF);

        // Enable drop mid-line
        n = 0;
        while (x_a != 10'd300 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ena = 1'b0;
        @(negedge clk);
        check("a_dis_xy", 32'({x_a, y_a}), 32'd0);
        check("a_dis_rgb", 32'(rgb_a), 32'h0);
        check("a_dis_sync", 32'({hs_a, vs_a}), 32'd3);
        c_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            c_pulse += int'(req_a) + int'(ls_a) + int'(fs_a);
            @(negedge clk);
        end
        check("a_dis_pulses", 32'(c_pulse), 32'd0);
        ena = 1'b1;
        n = 0;
        while (!fs_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("a_reen_fs_edge", 32'(n + 1), 32'd4);
        check("a_reen_xy", 32'({x_a, y_a}), 32'd0);

        // Asynchronous reset mid-line
        n = 0;
        while (x_a != 10'd101 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("a_pre_rst_rgb", 32'(rgb_a), 32'hFFF);
        #2;
        rst = 1'b1;
        #1;
        check("a_async_rgb", 32'(rgb_a), 32'h0);
        check("a_async_sync", 32'({hs_a, vs_a}), 32'd3);
        check("a_async_x", 32'(x_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!fs_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("a_post_rst_fs_edge", 32'(n + 1), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the board VGA port.
- Derives a pixel-rate enable from the 100 MHz board clock and runs horizontal/vertical counters through the active, front-porch, sync and back-porch phases.
- Requests pixel colour from an upstream renderer and drives registered, phase-aligned RGB/hsync/vsync to the pad output buffers.
- Default timing: 640x480 @ 60 Hz.

Parameters:
- CLK_DIV, 4: clk_ext cycles per pixel (1..16).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active-low).

Ports:
- clk_ext  input  1  board clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- enable  input  1  run timing; low forces the idle/blank state
- pix_rgb  input  12  {r[3:0],g[3:0],b[3:0]} for pixel at pix_x/pix_y, valid in the pix_req cycle
- pix_req  output  1  one-clk pulse: the current position is active and needs colour
- pix_x  output  10  current horizontal count (0..H_TOTAL-1)
- pix_y  output  10  current vertical count (0..V_TOTAL-1)
- frame_start  output  1  one-clk pulse at position (0,0)
- line_start  output  1  one-clk pulse at h=0 of every line
- vga_red  output  4  registered red
- vga_green  output  4  registered green
- vga_blue  output  4  registered blue
- vga_hsync  output  1  registered hsync
- vga_vsync  output  1  registered vsync

Behaviour:
- Clock and reset: one clock, clk_ext. Reset is asynchronous and active-high on rst.
- Reset values:
  - div, h, v counters = 0.
  - pix_req, frame_start, line_start = 0.
  - RGB = 0.
  - hsync/vsync = ~SYNC_POL (inactive).
- Derived constants:
  - H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
  - Counters are 10 bits; an elaboration check fails if either total exceeds 1024.
- Pixel tick:
  - div counts 0..CLK_DIV-1 while enable is high.
  - pix_tick = enable && div == CLK_DIV-1.
  - With CLK_DIV = 1, pix_tick = enable.
- Counters, on pix_tick:
  - h increments and wraps from H_TOTAL-1 to 0.
  - v increments only when h wraps, and wraps from V_TOTAL-1 to 0.
  - pix_x/pix_y are h/v directly.
- Phase FSM per axis: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - h phase thresholds: H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, H_TOTAL.
  - v phase uses the V_* thresholds the same way.
  - Phase is decoded from the counter value and held in a registered state.
  - The state always matches the counter.
- Request: pix_req = pix_tick && h_phase == ACTIVE && v_phase == ACTIVE. It is combinational from registered state.
- Pixel output, registered on the pix_tick edge:
  - vga_rgb <= (h and v both ACTIVE) ? pix_rgb : 0.
  - vga_hsync <= (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL.
  - vga_vsync <= (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL.
  - Latency is one pixel tick. RGB and syncs stay mutually aligned and hold between ticks.
- Pulses:
  - frame_start = pix_tick && h == 0 && v == 0.
  - line_start = pix_tick && h == 0.
  - Both coincide with pix_req at (0,0).
- enable low, including mid-frame:
  - On the next clk edge: div/h/v = 0, RGB = 0, syncs inactive.
  - No pulses while enable is low.
- enable rising: the first pix_tick occurs CLK_DIV clks later, at (0,0), with frame_start asserted.
- Requester not ready: pix_rgb is sampled unconditionally. There is no back-pressure, and the renderer must answer in the same cycle.
- Reset mid-frame: all state returns to the reset values immediately. Counting restarts CLK_DIV clks after rst deasserts, if enable is high.

Decomposition:
- Shared timing-constants header: default 640x480 parameter values, phase encoding (ACTIVE=0, FP=1, SYNC=2, BP=3), RGB field widths.
- One natural sub-module, vga_axis_counter: a parameterised wrap counter plus phase decoder with count_en, wrap output, count, and phase.
  - Instantiated twice: horizontal axis with count_en = pix_tick; vertical axis with count_en = h wrap.

Test Plan:
- Reset: assert rst asynchronously mid-line -> all outputs immediately take reset values (hsync/vsync = 1, RGB = 0). After release with enable = 1, the first frame_start occurs exactly 4 clks later.
- Line timing (defaults): count pix_tick from line_start -> hsync low for exactly 96 ticks starting at h = 656 (output seen at tick 657); line_start period = 3200 clks.
- Frame timing: consecutive frame_start pulses are 1,680,000 clks apart; vsync low for 2 lines starting at v = 490; exactly 307,200 pix_req per frame.
- Colour path: renderer returns pix_rgb = {pix_x[3:0], pix_y[3:0], 4'hA} -> RGB at the tick after request (x=5, y=3) equals 12'h53A; RGB = 0 throughout porch and sync regions even with pix_rgb = 12'hFFF.
- Enable drop at (x=300, y=200) -> next clk counters = 0, RGB = 0, syncs = 1, no pulses. Re-enable -> frame_start 4 clks later at (0,0).
- CLK_DIV = 1, SYNC_POL = 1 variant -> pix_tick every clk; hsync high for 96 clks per 800-clk line; frame period = 420,000 clks.
